// File: rtl/sa_inst_sequencer.sv
// sa_inst_sequencer
// Instruction sequencer for the systolic-array datapath. Instructions enter
// through a small valid/ready queue and are decoded one at a time. Each one
// runs as a burst of len+1 beats, and the write/read addresses advance by one
// after every beat.
//
// Ports
//   clk, reset_n          rising-edge clock, synchronous active-low reset
//   inst_valid/inst_ready instruction handshake (ready = queue not full)
//   instruction           {opcode, addra, addrb, len}, MSB first
//   axi_sm_mode           0 idle, 1 load-off-memory (only while requesting)
//   axi_txn_en            AXI beat request; inst_done/din return the beat
//   rin                   accumulator result written back to the UB
//   read_*/write_*/..._en datapath strobes, addra/addrb addresses, dout data
//   busy/done/err         status: busy, last-beat pulse, illegal-opcode pulse
module sa_inst_sequencer #(
  parameter int OPCODE_BITS = 4,
  parameter int ADDRA_BITS  = 10,
  parameter int ADDRB_BITS  = 10,
  parameter int LEN_BITS    = 8,
  parameter int INST_BITS   = OPCODE_BITS + ADDRA_BITS + ADDRB_BITS + LEN_BITS,
  parameter int DIN_BITS    = 128,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  input  logic [INST_BITS-1:0]  instruction,
  output logic [1:0]            axi_sm_mode,
  output logic                  axi_txn_en,
  input  logic                  inst_done,
  input  logic [DIN_BITS-1:0]   din,
  input  logic [DIN_BITS-1:0]   rin,
  output logic                  read_ub,
  output logic                  write_ub,
  output logic                  read_wb,
  output logic                  write_wb,
  output logic                  read_acc,
  output logic                  write_acc,
  output logic                  data_fifo_en,
  output logic                  mmu_load_weight_en,
  output logic                  weight_fifo_en,
  output logic                  mm_en,
  output logic                  acc_en,
  output logic [ADDRA_BITS-1:0] addra,
  output logic [ADDRB_BITS-1:0] addrb,
  output logic [DIN_BITS-1:0]   dout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS + 1)'(QUEUE_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXEC    = 3'd1;
  localparam logic [2:0] S_AXI_REQ = 3'd2;
  localparam logic [2:0] S_AXI_GAP = 3'd3;
  localparam logic [2:0] S_ACC_RD  = 3'd4;
  localparam logic [2:0] S_ACC_WR  = 3'd5;

  localparam logic [OPCODE_BITS-1:0] OP_DATA_FIFO   = OPCODE_BITS'(1);
  localparam logic [OPCODE_BITS-1:0] OP_WEIGHT_FIFO = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] OP_AXI_TO_UB   = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_AXI_TO_WB   = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] OP_UB_TO_DF    = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] OP_UB_TO_WF    = OPCODE_BITS'(6);
  localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL     = OPCODE_BITS'(7);
  localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL_ACC = OPCODE_BITS'(8);
  localparam logic [OPCODE_BITS-1:0] OP_ACC_TO_UB   = OPCODE_BITS'(9);

  logic [INST_BITS-1:0]   queue_mem_r [QUEUE_DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr_r, rd_ptr_r;
  logic [PTR_BITS:0]      count_r;
  logic                   empty_s, full_s, push_s, pop_s;
  logic [INST_BITS-1:0]   head_s;
  logic [OPCODE_BITS-1:0] head_op_s;
  logic                   legal_s;

  logic [2:0]             state_r, state_nxt_s;
  logic [OPCODE_BITS-1:0] op_r, op_nxt_s;
  logic [LEN_BITS-1:0]    cnt_r, cnt_nxt_s;
  logic [ADDRA_BITS-1:0]  addra_r, addra_nxt_s;
  logic [ADDRB_BITS-1:0]  addrb_r, addrb_nxt_s;
  logic                   last_s, adv_s;

  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == DEPTH_CNT);
  assign inst_ready = !full_s;
  assign push_s     = inst_valid && !full_s;
  // Only S_IDLE consumes the queue, so a burst never overlaps the next decode.
  assign pop_s      = (state_r == S_IDLE) && !empty_s;
  assign head_s     = queue_mem_r[rd_ptr_r];
  assign head_op_s  = head_s[INST_BITS-1 -: OPCODE_BITS];
  assign legal_s    = (head_op_s <= OP_ACC_TO_UB);
  assign last_s     = (cnt_r == '0);
  assign busy       = (state_r != S_IDLE) || !empty_s;
  assign addra      = addra_r;
  assign addrb      = addrb_r;

  // Queue pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_BITS'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_BITS + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_BITS + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; entries are only read while count_r marks them valid.
  always_ff @(posedge clk) begin
    if (push_s) queue_mem_r[wr_ptr_r] <= instruction;
  end

  // Next-state, decode on pop and per-beat address/counter advance.
  always_comb begin
    state_nxt_s = state_r;
    op_nxt_s    = op_r;
    cnt_nxt_s   = cnt_r;
    addra_nxt_s = addra_r;
    addrb_nxt_s = addrb_r;
    adv_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        // An illegal opcode is dropped here: err/done pulse, state unchanged.
        if (pop_s && legal_s) begin
          op_nxt_s    = head_op_s;
          addra_nxt_s = head_s[LEN_BITS + ADDRB_BITS +: ADDRA_BITS];
          addrb_nxt_s = head_s[LEN_BITS +: ADDRB_BITS];
          cnt_nxt_s   = head_s[LEN_BITS-1:0];
          case (head_op_s)
            OP_AXI_TO_UB, OP_AXI_TO_WB: state_nxt_s = S_AXI_REQ;
            OP_ACC_TO_UB:               state_nxt_s = S_ACC_RD;
            default:                    state_nxt_s = S_EXEC;
          endcase
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC: begin
        if (last_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          adv_s       = 1'b1;
          state_nxt_s = S_EXEC;
        end
      end
      S_AXI_REQ: begin
        if (inst_done) begin
          if (last_s) begin
            state_nxt_s = S_IDLE;
          end else begin
            adv_s       = 1'b1;
            state_nxt_s = S_AXI_GAP;
          end
        end else begin
          state_nxt_s = S_AXI_REQ;
        end
      end
      // The gap drops axi_txn_en so the next request shows a rising edge.
      S_AXI_GAP: state_nxt_s = S_AXI_REQ;
      S_ACC_RD:  state_nxt_s = S_ACC_WR;
      S_ACC_WR: begin
        if (last_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          adv_s       = 1'b1;
          state_nxt_s = S_ACC_RD;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
    if (adv_s) begin
      cnt_nxt_s   = cnt_r - LEN_BITS'(1);
      addra_nxt_s = addra_r + ADDRA_BITS'(1);
      addrb_nxt_s = addrb_r + ADDRB_BITS'(1);
    end else begin
      cnt_nxt_s   = cnt_nxt_s;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      op_r    <= '0;
      cnt_r   <= '0;
      addra_r <= '0;
      addrb_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      op_r    <= op_nxt_s;
      cnt_r   <= cnt_nxt_s;
      addra_r <= addra_nxt_s;
      addrb_r <= addrb_nxt_s;
    end
  end

  // Datapath strobes and status, decoded from the registered state.
  always_comb begin
    axi_sm_mode        = 2'd0;
    axi_txn_en         = 1'b0;
    read_ub            = 1'b0;
    write_ub           = 1'b0;
    read_wb            = 1'b0;
    write_wb           = 1'b0;
    read_acc           = 1'b0;
    write_acc          = 1'b0;
    data_fifo_en       = 1'b0;
    mmu_load_weight_en = 1'b0;
    weight_fifo_en     = 1'b0;
    mm_en              = 1'b0;
    acc_en             = 1'b0;
    dout               = '0;
    done               = 1'b0;
    err                = 1'b0;
    case (state_r)
      S_IDLE: begin
        err  = pop_s && !legal_s;
        done = pop_s && !legal_s;
      end
      S_EXEC: begin
        done = last_s;
        case (op_r)
          OP_DATA_FIFO:   data_fifo_en = 1'b1;
          OP_WEIGHT_FIFO: weight_fifo_en = 1'b1;
          OP_UB_TO_DF: begin
            read_ub      = 1'b1;
            data_fifo_en = 1'b1;
          end
          OP_UB_TO_WF: begin
            read_wb            = 1'b1;
            mmu_load_weight_en = 1'b1;
            weight_fifo_en     = 1'b1;
          end
          OP_MAT_MUL, OP_MAT_MUL_ACC: begin
            read_ub      = 1'b1;
            data_fifo_en = 1'b1;
            mm_en        = 1'b1;
            write_acc    = 1'b1;
            acc_en       = (op_r == OP_MAT_MUL_ACC);
          end
          default: acc_en = 1'b0;
        endcase
      end
      S_AXI_REQ: begin
        axi_sm_mode = 2'd1;
        if (inst_done) begin
          write_ub = (op_r == OP_AXI_TO_UB);
          write_wb = (op_r != OP_AXI_TO_UB);
          dout     = din;
          done     = last_s;
        end else begin
          axi_txn_en = 1'b1;
        end
      end
      S_ACC_RD: read_acc = 1'b1;
      S_ACC_WR: begin
        write_ub = 1'b1;
        dout     = rin;
        done     = last_s;
      end
      default: done = 1'b0;
    endcase
  end

endmodule
